chien_search: RTL
=================

# chien_search

Chien root search for the BCH(15,7), t=2 decoder over GF(16) (primitive polynomial x^4+x+1). Sits directly downstream of Berlekamp-Massey stage 2. It consumes the error-locator coefficients λ1 and λ2 of Λ(x)=1+λ1·x+λ2·x². It sequentially evaluates Λ(α^-j) for j=0..14 and emits a 15-bit error pattern, a root count and a decode-failure flag through a valid/ready handshake.

## Interface
- No parameters. Code length N=15 and field constants come from `bch_pkg`.
- `clk`  in  1  single clock; all logic on the rising edge
- `rst`  in  1  synchronous, active-high reset
- `in_valid`  in  1  λ1/λ2 (and `cw_i`) valid
- `in_ready`  out  1  block can accept new coefficients
- `l1`  in  4  λ1, GF(16) polynomial basis
- `l2`  in  4  λ2, GF(16) polynomial basis
- `cw_i`  in  15  received codeword, bit j = coefficient of x^j (used only with `CHIEN_CORRECT_EN`)
- `out_valid`  out  1  result valid
- `out_ready`  in  1  downstream accepts result
- `err_vec`  out  15  bit j set when Λ(α^-j)=0
- `err_cnt`  out  2  number of roots found, saturating at 3
- `fail`  out  1  uncorrectable codeword (root count ≠ degree of Λ)
- `cw_o`  out  15  corrected codeword (with `CHIEN_CORRECT_EN` only)

## Operation
- FSM states: IDLE, SEARCH, DONE.
  - IDLE: `in_ready`=1. When `in_valid`=1, load t1←λ1, t2←λ2 and capture `cw_i`. Compute deg = 2 if λ2≠0, 1 if λ2=0 and λ1≠0, otherwise 0. Clear `err_vec`, clear the root count, set pos←0, go to SEARCH.
  - SEARCH: each cycle evaluate e = 1 ⊕ t1 ⊕ t2. If e=0, set `err_vec[pos]` and increment the count (saturating at 3). Then t1←t1·α^14, t2←t2·α^13, pos←pos+1. After pos=14 is evaluated, go to DONE.
  - DONE: `out_valid`=1 and all outputs are held stable. Go to IDLE on `out_ready`=1.
- `fail` = (root count ≠ deg), computed at entry to DONE and held.
- λ1=λ2=0 yields `err_vec`=0, `err_cnt`=0, `fail`=0.
- `in_valid` is ignored outside IDLE. `in_ready` depends only on state, never combinationally on `in_valid`.
- Reset values: state IDLE, `in_ready`=1 (after reset is released), `out_valid`=0, `err_vec`=0, `err_cnt`=0, `fail`=0, `cw_o`=0, internal t1/t2/pos=0.
- Reset asserted mid-SEARCH or in DONE aborts the search. The next cycle is IDLE with all outputs at their reset values, and no partial result is presented.

## Timing
- Acceptance edge A: the edge where `in_valid`&&`in_ready`.
- Positions 0..14 are evaluated in the cycles after A and registered on edges A+1..A+15.
- `out_valid` rises in the cycle after edge A+15, a latency of 16 cycles.
- With `out_ready` held at 1: DONE lasts 1 cycle, IDLE lasts at least 1 cycle. Maximum throughput is one codeword per 17 cycles.
- `out_valid`, once high, stays high until the handshake completes. Outputs do not change while `out_valid`=1 and `out_ready`=0.
- Field arithmetic: XOR addition. Constant multiplies by α^14 and α^13 are pure XOR networks reduced mod x^4+x+1, with no multi-cycle arithmetic.

## Configuration
- `CHIEN_CORRECT_EN` defined: `cw_i` is captured at acceptance. In DONE, `cw_o` = captured cw ⊕ `err_vec` when `fail`=0, and the captured cw unmodified when `fail`=1.
- `CHIEN_CORRECT_EN` undefined: no codeword register is built, `cw_i` is ignored and `cw_o` is tied to 0.
- Ports exist in both builds.

## Structure
- `bch_pkg` holds:
  - `GF_POLY`=4'b0011 (x^4 term implicit), `N`=15, `K`=7
  - `ALPHA_INV1`=4'h9 (α^14), `ALPHA_INV2`=4'hD (α^13)
  - the `gf_t` 4-bit typedef and the `chien_state_t` enum
- One sub-module, `gf_mul_const`: a parameterised constant multiplier (parameter = constant operand). It is instantiated twice, for t1 and t2.

## Test plan
- Single error: λ1=4'h8 (α^3), λ2=0, `cw_i`=15'h0008 (CHIEN_CORRECT_EN) → `err_vec`=15'h0008, `err_cnt`=1, `fail`=0, `cw_o`=0. `out_valid` appears exactly 16 cycles after acceptance.
- Double error: λ1=4'h7, λ2=4'h6 (Λ=(1+x)(1+α^5x)) → `err_vec`=15'h0021, `err_cnt`=2, `fail`=0.
- No error: λ1=λ2=0 → `err_vec`=0, `err_cnt`=0, `fail`=0.
- Failure: λ1=0, λ2=1 (Λ=(1+x)², deg 2, single distinct root) → `err_vec`=15'h0001, `err_cnt`=1, `fail`=1. With CHIEN_CORRECT_EN, `cw_o`=`cw_i`.
- Backpressure: hold `out_ready`=0 for 10 cycles after `out_valid` → outputs stable and `in_ready`=0 throughout. One cycle after `out_ready`=1, `in_ready`=1.
- Reset mid-search: assert `rst` at SEARCH pos=7 → next cycle IDLE, all outputs 0, `out_valid` never pulses. A fresh λ1=4'h8 then gives the single-error result.

Source files
------------

// File: rtl/bch_pkg.sv
// Field constants, types and GF(16) helpers for the BCH(15,7) t=2 decoder.
package bch_pkg;
   localparam int N = 15;
   localparam int K = 7;
   localparam logic [3:0] GF_POLY    = 4'b0011;  // x^4 term implicit
   localparam logic [3:0] ALPHA_INV1 = 4'h9;     // alpha^14 = alpha^-1
   localparam logic [3:0] ALPHA_INV2 = 4'hD;     // alpha^13 = alpha^-2

   typedef logic [3:0] gf_t;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SEARCH = 2'd1,
      DONE   = 2'd2
   } chien_state_t;

   // Shift-and-add product; with one constant operand this folds to a pure XOR network.
   function automatic gf_t gf_mul(input gf_t a, input gf_t b);
      gf_t p;
      gf_t s;
      p = '0;
      s = a;
      for (int i = 0; i < 4; i++) begin
         if (b[i]) p = p ^ s;
         s = s[3] ? ({s[2:0], 1'b0} ^ GF_POLY) : {s[2:0], 1'b0};
      end
      return p;
   endfunction
endpackage

// File: rtl/gf_mul_const.sv
// GF(16) multiply by a constant chosen at elaboration time; combinational.
module gf_mul_const
   import bch_pkg::*;
#(
   parameter gf_t C = 4'h1
) (
   input  logic [3:0] a,
   output logic [3:0] y
);
   assign y = gf_mul(a, C);
endmodule

// File: rtl/chien_search.sv
// Chien root search for BCH(15,7) t=2: one position per cycle, result 16 cycles after acceptance,
// held under out_valid until out_ready. Define CHIEN_CORRECT_EN to build the codeword corrector.
module chien_search
   import bch_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [3:0]  l1,
   input  logic [3:0]  l2,
   input  logic [14:0] cw_i,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [14:0] err_vec,
   output logic [1:0]  err_cnt,
   output logic        fail,
   output logic [14:0] cw_o
);
   chien_state_t state, state_nx;
   gf_t         t1, t2, t1_nx, t2_nx;
   logic [3:0]  pos;
   logic [1:0]  deg;
   logic        hit;
   logic        last;
   logic [1:0]  cnt_nx;
   logic [14:0] vec_nx;

   gf_mul_const #(.C(ALPHA_INV1)) u_mul_t1 (.a(t1), .y(t1_nx));
   gf_mul_const #(.C(ALPHA_INV2)) u_mul_t2 (.a(t2), .y(t2_nx));

   assign hit  = ((4'h1 ^ t1 ^ t2) == 4'h0);
   assign last = (pos == 4'd14);

   always_comb begin
      cnt_nx = err_cnt;
      vec_nx = err_vec;
      if (hit) begin
         vec_nx[pos] = 1'b1;
         if (err_cnt != 2'd3) cnt_nx = err_cnt + 2'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (in_valid) state_nx = SEARCH;
         SEARCH:  if (last)     state_nx = DONE;
         DONE:    if (out_ready) state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_comb begin
      in_ready  = (state == IDLE);
      out_valid = (state == DONE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         t1      <= '0;
         t2      <= '0;
         pos     <= '0;
         deg     <= '0;
         err_vec <= '0;
         err_cnt <= '0;
         fail    <= 1'b0;
      end else begin
         case (state)
            IDLE: if (in_valid) begin
               t1      <= l1;
               t2      <= l2;
               pos     <= '0;
               deg     <= (l2 != 4'h0) ? 2'd2 : ((l1 != 4'h0) ? 2'd1 : 2'd0);
               err_vec <= '0;
               err_cnt <= '0;
               fail    <= 1'b0;
            end
            SEARCH: begin
               t1      <= t1_nx;
               t2      <= t2_nx;
               pos     <= pos + 4'd1;
               err_vec <= vec_nx;
               err_cnt <= cnt_nx;
               if (last) fail <= (cnt_nx != deg);
            end
            default: ;
         endcase
      end
   end

`ifdef CHIEN_CORRECT_EN
   logic [14:0] cw_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         cw_q <= '0;
         cw_o <= '0;
      end else begin
         if (state == IDLE && in_valid) cw_q <= cw_i;
         // Uncorrectable words pass through untouched rather than being mis-corrected.
         if (state == SEARCH && last) cw_o <= (cnt_nx != deg) ? cw_q : (cw_q ^ vec_nx);
      end
   end
`else
   logic unused_cw;
   assign unused_cw = ^cw_i;
   assign cw_o      = '0;
`endif
endmodule
